// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Writes a length-prefixed program image, one byte per cycle, into a
// 2048-byte little-endian instruction memory starting at address 0. It also
// provides a combinational 32-bit fetch port, so it can stand in for the
// instruction ROM. While a load is running, o_cpu_hold keeps the core stalled.
//
// Stream: LEN_LO, LEN_HI, N data bytes, [XOR checksum byte]
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN
//   defined   : a trailing XOR checksum byte is expected and checked (CHK state)
//   undefined : no checksum; the last data byte (or LEN_HI when N=0) ends in DONE
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             one-cycle load request (ignored while busy)
//   i_byte_valid/i_byte stream byte input
//   o_byte_ready        byte accepted this cycle when valid
//   i_addr / o_data     combinational fetch: bytes i_addr..i_addr+3, LE, mod DEPTH
//   o_busy, o_cpu_hold  load in progress (identical)
//   o_done, o_error     result of the last load (levels)
//
// state  | meaning
// IDLE   | no load since reset
// LEN_LO | waiting for length low byte
// LEN_HI | waiting for length high byte
// DATA   | writing data bytes to memory
// CHK    | waiting for checksum byte (checksum build only)
// DONE   | last load completed
// ERR    | last load aborted (oversize length or bad checksum)
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  output logic          o_byte_ready,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_data,
  output logic          o_busy,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Where the stream goes once the data bytes are exhausted.
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam logic [2:0] S_AFTER_DATA = S_CHK;
`else
  localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

  logic [2:0]    state;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic [7:0]    len_lo;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]    acc;
`endif

  logic [7:0] mem [DEPTH];

  logic        xfer;
  logic [15:0] len_n;
  logic        len_over;
  logic        busy;

  assign busy     = (state == S_LEN_LO) || (state == S_LEN_HI) || (state == S_DATA)
`ifdef IMEM_LOAD_CHECKSUM_EN
                    || (state == S_CHK)
`endif
                    ;
  assign xfer     = i_byte_valid && busy;
  assign len_n    = {i_byte, len_lo};
  assign len_over = len_n > 16'(DEPTH);

  assign o_byte_ready = busy;
  assign o_busy       = busy;
  assign o_cpu_hold   = busy;
  assign o_done       = (state == S_DONE);
  assign o_error      = (state == S_ERR);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      remaining <= '0;
      len_lo    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      acc       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            state <= S_LEN_LO;
            ptr   <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            acc   <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= i_byte;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            remaining <= len_n[AW:0];
            if (len_over)
              state <= S_ERR;
            else if (len_n == 16'd0)
              state <= S_AFTER_DATA;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            // ptr wraps to 0 after a full DEPTH-byte load; state leaves DATA on
            // that same edge, so the wrapped pointer is never written through.
            ptr       <= ptr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            acc       <= acc ^ i_byte;
`endif
            if (remaining == (AW+1)'(1))
              state <= S_AFTER_DATA;
          end
        end
`ifdef IMEM_LOAD_CHECKSUM_EN
        S_CHK: begin
          if (xfer)
            state <= (i_byte == acc) ? S_DONE : S_ERR;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset: contents survive both reset and aborted loads.
  always_ff @(posedge i_clk) begin
    if (!i_reset && (state == S_DATA) && xfer)
      mem[ptr] <= i_byte;
  end

  logic [AW-1:0] a1, a2, a3;
  assign a1 = i_addr + AW'(1);
  assign a2 = i_addr + AW'(2);
  assign a3 = i_addr + AW'(3);

  assign o_data = {mem[a3], mem[a2], mem[a1], mem[i_addr]};

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_byte_ready;
  logic [10:0] i_addr;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;

  int checks   = 0;
  int failures = 0;
  int hold_cnt = 0;

  logic [7:0] stim [0:2100];

`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam int CHK_N = 1;
`else
  localparam int CHK_N = 0;
`endif

  imem_loader #(.DEPTH(2048), .AW(11)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .i_addr       (i_addr),
    .o_data       (o_data),
    .o_busy       (o_busy),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_cpu_hold) hold_cnt++;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Sends stim[0..n-1]; with toggle, a garbage byte with valid low precedes each real one.
  task automatic send(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        i_byte_valid = 1'b0;
        i_byte       = 8'hFF;
        tick();
      end
      i_byte_valid = 1'b1;
      i_byte       = stim[i];
      tick();
    end
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
  endtask

  task automatic load_basic_stim();
    stim[0] = 8'h04; stim[1] = 8'h00;
    stim[2] = 8'h13; stim[3] = 8'h05; stim[4] = 8'h10; stim[5] = 8'h00;
    stim[6] = 8'h06;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00; i_addr = '0;
    tick(); tick();
    i_reset = 1'b0;
    tick();
    checks++;
    if ({o_byte_ready, o_busy, o_cpu_hold, o_done, o_error} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {o_byte_ready, o_busy, o_cpu_hold, o_done, o_error});
    end
  endtask

  task automatic test_basic();
    load_basic_stim();
    hold_cnt = 0;
    pulse_start();
    checks++;
    if ({o_busy, o_byte_ready, o_cpu_hold} !== 3'b111) begin
      failures++;
      $display("FAIL start_busy: got %b expected 111", {o_busy, o_byte_ready, o_cpu_hold});
    end
    send(6 + CHK_N, 1'b0);
    checks++;
    if ({o_done, o_error, o_busy, o_byte_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_done: got %b expected 1000", {o_done, o_error, o_busy, o_byte_ready});
    end
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h00100513) begin
      failures++;
      $display("FAIL basic_fetch0: got %h expected 00100513", o_data);
    end
    tick();
    checks++;
    if (hold_cnt !== 6 + CHK_N) begin
      failures++;
      $display("FAIL basic_hold_cycles: got %0d expected %0d", hold_cnt, 6 + CHK_N);
    end
  endtask

  task automatic test_valid_toggle();
    load_basic_stim();
    hold_cnt = 0;
    pulse_start();
    send(6 + CHK_N, 1'b1);
    checks++;
    if ({o_done, o_error} !== 2'b10) begin
      failures++;
      $display("FAIL toggle_done: got %b expected 10", {o_done, o_error});
    end
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h00100513) begin
      failures++;
      $display("FAIL toggle_fetch0: got %h expected 00100513", o_data);
    end
    tick();
    checks++;
    if (hold_cnt !== 2 * (6 + CHK_N)) begin
      failures++;
      $display("FAIL toggle_hold_cycles: got %0d expected %0d", hold_cnt, 2 * (6 + CHK_N));
    end
  endtask

  task automatic test_oversize();
    stim[0] = 8'h01; stim[1] = 8'h08;
    pulse_start();
    send(2, 1'b0);
    checks++;
    if ({o_error, o_done, o_byte_ready, o_busy} !== 4'b1000) begin
      failures++;
      $display("FAIL oversize_err: got %b expected 1000", {o_error, o_done, o_byte_ready, o_busy});
    end
    stim[0] = 8'hAA; stim[1] = 8'hBB;
    send(2, 1'b0);
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h00100513) begin
      failures++;
      $display("FAIL oversize_mem_kept: got %h expected 00100513", o_data);
    end
    checks++;
    if ({o_error, o_byte_ready} !== 2'b10) begin
      failures++;
      $display("FAIL oversize_stays_err: got %b expected 10", {o_error, o_byte_ready});
    end
  endtask

  task automatic test_zero_len();
    stim[0] = 8'h00; stim[1] = 8'h00; stim[2] = 8'h00;
    pulse_start();
    send(2 + CHK_N, 1'b0);
    checks++;
    if ({o_done, o_error, o_busy} !== 3'b100) begin
      failures++;
      $display("FAIL zero_len_done: got %b expected 100", {o_done, o_error, o_busy});
    end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_bad_checksum();
    stim[0] = 8'h02; stim[1] = 8'h00; stim[2] = 8'h11; stim[3] = 8'h22; stim[4] = 8'h00;
    pulse_start();
    send(5, 1'b0);
    checks++;
    if ({o_error, o_done, o_busy} !== 3'b100) begin
      failures++;
      $display("FAIL badchk_err: got %b expected 100", {o_error, o_done, o_busy});
    end
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h00102211) begin
      failures++;
      $display("FAIL badchk_mem: got %h expected 00102211", o_data);
    end
  endtask
`endif

  task automatic test_full();
    stim[0] = 8'h00; stim[1] = 8'h08;
    for (int i = 0; i < 2048; i++) stim[i + 2] = 8'(i);
    stim[2050] = 8'h00; // XOR of 0..255 repeated eight times is zero
    pulse_start();
    send(2050 + CHK_N, 1'b0);
    checks++;
    if ({o_done, o_error, o_busy} !== 3'b100) begin
      failures++;
      $display("FAIL full_done: got %b expected 100", {o_done, o_error, o_busy});
    end
    i_addr = 11'd2047; #1;
    checks++;
    if (o_data !== 32'h020100FF) begin
      failures++;
      $display("FAIL full_fetch_wrap: got %h expected 020100FF", o_data);
    end
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h03020100) begin
      failures++;
      $display("FAIL full_fetch0: got %h expected 03020100", o_data);
    end
    i_addr = 11'd1302; #1;
    checks++;
    if (o_data !== 32'h19181716) begin
      failures++;
      $display("FAIL full_fetch1302: got %h expected 19181716", o_data);
    end
  endtask

  task automatic test_reset_mid_and_start_ignored();
    stim[0] = 8'h10; stim[1] = 8'h00; stim[2] = 8'hA1; stim[3] = 8'hA2; stim[4] = 8'hA3;
    pulse_start();
    send(5, 1'b0);
    // Reset together with a start and a valid byte: reset must win.
    i_reset = 1'b1; i_start = 1'b1; i_byte_valid = 1'b1; i_byte = 8'hEE;
    tick();
    i_reset = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0;
    checks++;
    if ({o_busy, o_byte_ready, o_done, o_error} !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_idle: got %b expected 0000", {o_busy, o_byte_ready, o_done, o_error});
    end
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h03A3A2A1) begin
      failures++;
      $display("FAIL midreset_partial_mem: got %h expected 03A3A2A1", o_data);
    end
    // New load; a start pulse after LEN_LO must not restart the header.
    pulse_start();
    stim[0] = 8'h02;
    send(1, 1'b0);
    pulse_start();
    stim[0] = 8'h00; stim[1] = 8'h55; stim[2] = 8'h66; stim[3] = 8'h33;
    send(3 + CHK_N, 1'b0);
    checks++;
    if ({o_done, o_error, o_busy} !== 3'b100) begin
      failures++;
      $display("FAIL restart_done: got %b expected 100", {o_done, o_error, o_busy});
    end
    i_addr = 11'd0; #1;
    checks++;
    if (o_data !== 32'h03A36655) begin
      failures++;
      $display("FAIL restart_mem: got %h expected 03A36655", o_data);
    end
  endtask

  task automatic test_same_cycle_fetch();
    // Fetch of the byte being written shows old value before the edge, new after.
    stim[0] = 8'h01; stim[1] = 8'h00;
    pulse_start();
    send(2, 1'b0);
    i_addr = 11'd0;
    i_byte_valid = 1'b1; i_byte = 8'h77; #1;
    checks++;
    if (o_data !== 32'h03A36655) begin
      failures++;
      $display("FAIL write_same_cycle: got %h expected 03A36655", o_data);
    end
    tick();
    i_byte_valid = 1'b0;
    checks++;
    if (o_data !== 32'h03A36677) begin
      failures++;
      $display("FAIL write_next_cycle: got %h expected 03A36677", o_data);
    end
    stim[0] = 8'h77;
    send(CHK_N, 1'b0);
    checks++;
    if (o_done !== 1'b1) begin
      failures++;
      $display("FAIL write_done: got %b expected 1", o_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_valid_toggle();
    test_oversize();
    test_zero_len();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_full();
    test_reset_mid_and_start_ignored();
    test_same_cycle_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
